// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential MAC neuron shared by all MLP layers.
// Streams N_INPUTS activations, multiplies each by a weight fetched from a
// sync-read ROM, adds the bias, saturates to DATA_W and returns the result
// through a valid/ready handshake.
// Optional feature macro: NEURON_RELU_EN (clamp negative results to zero).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/neuron/bias   begin a neuron; index and bias sampled with start
//   in_valid/in_data    activation stream, accepted when in_ready is high
//   in_ready            block is in its MAC phase
//   w_addr/w_data       weight ROM address (combinational) / data one cycle later
//   out_valid/out_ready result handshake
//   out/sat             result and saturation flag, held until next result
//   busy                state is not IDLE
//   err                 one-cycle pulse for start with an out-of-range index
module neuron_mac_seq #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 200,
  parameter int ACC_W     = 40,
  parameter int NEU_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int ADDR_W    = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NEU_W-1:0]  neuron,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              sat,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(N_INPUTS + 1);
  localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_D = ~MAX_D;
  localparam logic signed [ACC_W-1:0]  MAX_R = ACC_W'(MAX_D);
  localparam logic signed [ACC_W-1:0]  MIN_R = ACC_W'(MIN_D);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_OUT} state_t;

  state_t                     state, state_next;
  logic [NEU_W-1:0]           neuron_q;
  logic signed [DATA_W-1:0]   bias_q;
  logic signed [ACC_W-1:0]    acc;
  logic [IDX_W-1:0]           idx, idx_next;
  logic                       accept, start_ok, start_bad, last_beat;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum, r;
  logic signed [DATA_W-1:0]   r_sat, res;
  logic                       clip;
  logic [ADDR_W-1:0]          base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    last_beat  = (idx == IDX_W'(N_INPUTS - 1));
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if ({1'b0, neuron} < (NEU_W+1)'(N_NEURONS)) start_ok  = 1'b1;
          else                                        start_bad = 1'b1;
        end
        if (start_ok) state_next = S_MAC;
      end
      S_MAC: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && last_beat) state_next = S_BIAS;
      end
      S_BIAS: state_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address tracks the beat about to be accepted so the one-cycle ROM latency
  // lines w_data up with idx; in IDLE the port index pre-fetches weight 0.
  always_comb begin
    idx_next = idx;
    if (state == S_IDLE) idx_next = '0;
    else if (accept)     idx_next = idx + 1'b1;
    base   = ((state == S_IDLE) ? ADDR_W'(neuron) : ADDR_W'(neuron_q)) * ADDR_W'(N_INPUTS);
    w_addr = base + ADDR_W'(idx_next);
  end

  always_comb begin
    prod    = $signed(in_data) * $signed(w_data);
    acc_sum = acc + (ACC_W'(bias_q) <<< FRAC_W);
    r       = acc_sum >>> FRAC_W;
    clip    = 1'b0;
    r_sat   = r[DATA_W-1:0];
    if (r > MAX_R) begin
      r_sat = MAX_D;
      clip  = 1'b1;
    end else if (r < MIN_R) begin
      r_sat = MIN_D;
      clip  = 1'b1;
    end
`ifdef NEURON_RELU_EN
    res = r_sat[DATA_W-1] ? '0 : r_sat;
`else
    res = r_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neuron_q <= '0;
      bias_q   <= '0;
      acc      <= '0;
      idx      <= '0;
      out      <= '0;
      sat      <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= start_bad;
      unique case (state)
        S_IDLE: if (start_ok) begin
          neuron_q <= neuron;
          bias_q   <= bias;
          acc      <= '0;
          idx      <= '0;
        end
        S_MAC: if (accept) begin
          acc <= acc + ACC_W'(prod);
          idx <= idx_next;
        end
        S_BIAS: begin
          acc <= acc_sum;
          out <= res;
          sat <= clip;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  neuron;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        sat;
  logic        busy;
  logic        err;

  neuron_mac_seq #(
    .DATA_W(16), .FRAC_W(8), .N_INPUTS(4), .N_NEURONS(3), .ACC_W(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neuron(neuron), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sat(sat), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Weight ROM: neuron0 = 127.0 x4, neuron1 = 1,2,-1,0.5, neuron2 = 1.0 x4
  logic [15:0] rom [12];
  always @(posedge clk) w_data <= (w_addr < 4'd12) ? rom[w_addr] : 16'h0000;

  logic [15:0] acts [4];
  logic [16:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] model(input int n, input logic [15:0] b);
    longint s, r;
    logic [15:0] o;
    logic sa;
    s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(acts[i])) * longint'($signed(rom[n*4+i]));
    s += longint'($signed(b)) * 256;
    r = s >>> 8;
    sa = 1'b0;
    if (r > 32767) begin
      o = 16'h7FFF; sa = 1'b1;
    end else if (r < -32768) begin
      o = 16'h8000; sa = 1'b1;
    end else begin
      o = r[15:0];
    end
`ifdef NEURON_RELU_EN
    if (o[15]) o = 16'h0000;
`endif
    return {sa, o};
  endfunction

  task automatic run_neuron(input int n, input logic [15:0] b, input int stall_beat,
                            input int stall_len, input int hold);
    logic [16:0] e;
    logic [15:0] held;
    int cyc, base, stalls;
    base   = n * 4;
    stalls = (stall_beat >= 0 && stall_beat < 4) ? stall_len : 0;
    exp_q.push_back(model(n, b));
    start = 1'b1; neuron = 2'(n); bias = b;
    #1;
    check("waddr_idle", 32'(w_addr), base);
    tick;
    start = 1'b0; cyc = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0;
          #1;
          check("stall_waddr", 32'(w_addr), base + k);
          check("stall_ready", 32'(in_ready), 1);
          tick; cyc++;
        end
      end
      in_valid = 1'b1; in_data = acts[k];
      #1;
      check("beat_waddr", 32'(w_addr), base + k + 1);
      check("beat_ready", 32'(in_ready), 1);
      tick; cyc++;
    end
    in_valid = 1'b0;
    #1;
    check("bias_ready", 32'(in_ready), 0);
    for (int g = 0; g < 20 && !out_valid; g++) begin
      tick; cyc++;
    end
    check("latency", cyc, 6 + stalls);
    held = out;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; start = 1'b1; neuron = 2'd1;
      #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_stable", 32'(out), 32'(held));
      check("bp_err", 32'(err), 0);
      tick;
    end
    out_ready = 1'b1;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("result", 32'({sat, out}), 32'(e));
      end
    end else begin
      check("out_valid", 32'(out_valid), 1);
    end
    tick;
    out_ready = 1'b0; start = 1'b0;
    #1;
    check("post_valid", 32'(out_valid), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  initial begin
    rom = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
            16'h0100, 16'h0200, 16'hFF00, 16'h0080,
            16'h0100, 16'h0100, 16'h0100, 16'h0100};
    rst_n = 1'b0; start = 1'b0; neuron = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick; tick;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out", 32'({sat, out}), 0);
    rst_n = 1'b1;
    tick;

    // Basic: 1+2-1+0.5 plus bias 1.0 = 3.5 -> 0x0380
    acts = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    run_neuron(1, 16'h0100, -1, 0, 3);
    // Three-cycle stall between beats 1 and 2
    run_neuron(1, 16'h0100, 2, 3, 0);
    // Sum -3.0
    acts = '{16'hFF00, 16'hFF00, 16'hFF00, 16'h0000};
    run_neuron(2, 16'h0000, -1, 0, 1);
    // Negative clipping
    acts = '{16'h8100, 16'h8100, 16'h8100, 16'h8100};
    run_neuron(0, 16'h0000, -1, 0, 0);
    // Positive clipping, long back-pressure with start held
    acts = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    run_neuron(0, 16'h0000, 0, 1, 10);

    // Range error
    start = 1'b1; neuron = 2'd3;
    #1;
    check("rng_busy", 32'(busy), 0);
    check("rng_ready", 32'(in_ready), 0);
    tick;
    start = 1'b0;
    #1;
    check("rng_err", 32'(err), 1);
    check("rng_busy2", 32'(busy), 0);
    tick;
    check("rng_err_pulse", 32'(err), 0);

    // Reset during beat 2
    acts = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    start = 1'b1; neuron = 2'd1; bias = 16'h0100;
    tick;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = acts[k];
      tick;
    end
    in_data = acts[2];
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    check("mid_rst_out", 32'({sat, out}), 0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    run_neuron(1, 16'h0100, -1, 0, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
